// File: rtl/bounce_seq_ctl_if.sv
// Signal bundle between the bounce sequencer and the motion datapath / VGA timing.
// capture and step are single-cycle strobes with no back-pressure: the datapath must act in that cycle.
interface bounce_seq_ctl_if #(
    parameter int SPEED_W = 4
);
    logic               vblnk;
    logic               left;
    logic [11:0]        ypos;
    logic               capture;
    logic               step;
    logic               dir_down;
    logic [SPEED_W-1:0] speed;
    logic               settled;
    logic [3:0]         bounce_cnt;
    logic [2:0]         state_dbg;

    modport master (
        output vblnk, left, ypos,
        input  capture, step, dir_down, speed, settled, bounce_cnt, state_dbg
    );

    modport slave (
        input  vblnk, left, ypos,
        output capture, step, dir_down, speed, settled, bounce_cnt, state_dbg
    );
endinterface

// File: rtl/bounce_seq_ctl.sv
// Bouncing-rectangle sequencer: captures a drop height on click, then issues
// per-frame step pulses with direction and speed, halving the apex on each impact.
module bounce_seq_ctl #(
    parameter int FLOOR        = 536,
    parameter int ACCEL_FRAMES = 4,
    parameter int MAX_SPEED    = 8,
    parameter int MIN_H        = 16,
    parameter int SPEED_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    bounce_seq_ctl_if.slave  bus
);
    localparam logic [11:0]        FLOOR_Y  = 12'(FLOOR);
    localparam logic [11:0]        MIN_HY   = 12'(MIN_H);
    localparam logic [SPEED_W-1:0] SPD_MAX  = SPEED_W'(MAX_SPEED);
    localparam logic [SPEED_W-1:0] SPD_ONE  = SPEED_W'(1);
    localparam int                 ACC_W    = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
    localparam logic [ACC_W-1:0]   ACC_LAST = ACC_W'(ACCEL_FRAMES - 1);
    localparam logic [ACC_W-1:0]   ACC_ONE  = ACC_W'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CAPTURE = 3'd1,
        S_FALL    = 3'd2,
        S_RISE    = 3'd3,
        S_SETTLED = 3'd4
    } state_t;

    state_t             state;
    logic               left_s1, left_s2, left_s3, click_q;
    logic               vblnk_q;
    logic [11:0]        h, target;
    logic [ACC_W-1:0]   acc_cnt;
    logic [SPEED_W-1:0] speed_q;
    logic               dir_q, capture_q, settled_q;
    logic [3:0]         bounce_q;

    logic        tick, fall_hit, rise_hit, step_c, acc_wrap;
    logic [11:0] h_cap, h_half;

    always_comb begin
        tick     = bus.vblnk & ~vblnk_q;
        fall_hit = bus.ypos >= FLOOR_Y;
        rise_hit = bus.ypos <= target;
        step_c   = tick & (((state == S_FALL) & ~fall_hit) | ((state == S_RISE) & ~rise_hit));
        acc_wrap = acc_cnt == ACC_LAST;
        h_cap    = (bus.ypos < FLOOR_Y) ? (FLOOR_Y - bus.ypos) : 12'd0;
        h_half   = h >> 1;
    end

    // step is combinational so it lands in the tick cycle itself; dir_down follows it
    assign bus.step       = step_c;
    assign bus.dir_down   = step_c ? (state == S_FALL) : dir_q;
    assign bus.capture    = capture_q;
    assign bus.speed      = speed_q;
    assign bus.settled    = settled_q;
    assign bus.bounce_cnt = bounce_q;
    assign bus.state_dbg  = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            left_s1   <= 1'b0;
            left_s2   <= 1'b0;
            left_s3   <= 1'b0;
            click_q   <= 1'b0;
            vblnk_q   <= 1'b0;
            h         <= 12'd0;
            target    <= 12'd0;
            acc_cnt   <= '0;
            speed_q   <= '0;
            dir_q     <= 1'b0;
            capture_q <= 1'b0;
            settled_q <= 1'b0;
            bounce_q  <= 4'd0;
        end else begin
            left_s1   <= bus.left;
            left_s2   <= left_s1;
            left_s3   <= left_s2;
            click_q   <= left_s2 & ~left_s3;
            vblnk_q   <= bus.vblnk;
            capture_q <= 1'b0;
            if (step_c) dir_q <= (state == S_FALL);

            case (state)
                S_IDLE, S_SETTLED: begin
                    if (click_q) begin
                        state     <= S_CAPTURE;
                        capture_q <= 1'b1;
                        settled_q <= 1'b0;
                        bounce_q  <= 4'd0;
                    end
                end
                S_CAPTURE: begin
                    h       <= h_cap;
                    acc_cnt <= '0;
                    if (h_cap < MIN_HY) begin
                        state     <= S_SETTLED;
                        settled_q <= 1'b1;
                        speed_q   <= '0;
                    end else begin
                        state   <= S_FALL;
                        speed_q <= SPD_ONE;
                    end
                end
                S_FALL: begin
                    if (tick && fall_hit) begin
                        if (bounce_q != 4'd15) bounce_q <= bounce_q + 4'd1;
                        h       <= h_half;
                        acc_cnt <= '0;
                        if (h_half < MIN_HY) begin
                            state     <= S_SETTLED;
                            settled_q <= 1'b1;
                            speed_q   <= '0;
                        end else begin
                            state  <= S_RISE;
                            target <= FLOOR_Y - h_half;
                        end
                    end else if (step_c) begin
                        if (acc_wrap) begin
                            acc_cnt <= '0;
                            if (speed_q < SPD_MAX) speed_q <= speed_q + SPD_ONE;
                        end else begin
                            acc_cnt <= acc_cnt + ACC_ONE;
                        end
                    end
                end
                S_RISE: begin
                    if (tick && rise_hit) begin
                        state   <= S_FALL;
                        speed_q <= SPD_ONE;
                        acc_cnt <= '0;
                    end else if (step_c) begin
                        if (acc_wrap) begin
                            acc_cnt <= '0;
                            if (speed_q > SPD_ONE) speed_q <= speed_q - SPD_ONE;
                        end else begin
                            acc_cnt <= acc_cnt + ACC_ONE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bounce_seq_ctl.sv
// Bench for bounce_seq_ctl: phase-level reference model checked every cycle,
// a bench-side datapath that moves ypos, and directed scenarios with literal expectations.
module tb_bounce_seq_ctl;
  localparam int FLOOR = 536;
  localparam int ACCEL = 4;
  localparam int MAXS  = 8;
  localparam int MIN_H = 16;
  localparam int SW    = 4;

  localparam int P_IDLE = 0, P_CAP = 1, P_FALL = 2, P_RISE = 3, P_SETTLED = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  bounce_seq_ctl_if #(.SPEED_W(SW)) bus ();

  bounce_seq_ctl #(
    .FLOOR(FLOOR), .ACCEL_FRAMES(ACCEL), .MAX_SPEED(MAXS), .MIN_H(MIN_H), .SPEED_W(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phase-level view: speed follows from the number of steps issued in the
  // current phase; click is a pure delay line on the sampled button.
  int   m_phase = P_IDLE;
  int   m_h = 0;
  int   m_target = 0;
  int   m_n = 0;
  int   m_s0 = 0;
  int   m_bounce = 0;
  bit   m_dir = 0;
  bit   m_vb_prev = 0;
  bit   lh [4] = '{0, 0, 0, 0};
  int   m_targets [$];
  bit   m_click, m_tick, m_stp;
  int   m_spd;

  bit   dp_step = 0;
  bit   dp_dir = 0;
  int   dp_speed = 0;
  bit   dp_auto = 0;

  function automatic bit f_tick();
    return bus.vblnk && !m_vb_prev;
  endfunction

  function automatic bit f_step();
    return f_tick() && ((m_phase == P_FALL && int'(bus.ypos) < FLOOR) ||
                        (m_phase == P_RISE && int'(bus.ypos) > m_target));
  endfunction

  function automatic int f_speed();
    int s;
    s = 0;
    if (m_phase == P_FALL) begin
      s = 1 + m_n / ACCEL;
      if (s > MAXS) s = MAXS;
    end else if (m_phase == P_RISE) begin
      s = m_s0 - m_n / ACCEL;
      if (s < 1) s = 1;
    end
    return s;
  endfunction

  function automatic bit f_dir();
    return f_step() ? (m_phase == P_FALL) : m_dir;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = P_IDLE; m_h = 0; m_target = 0; m_n = 0; m_s0 = 0;
      m_bounce = 0; m_dir = 0; m_vb_prev = 0;
      lh = '{0, 0, 0, 0};
      dp_step = 0;
    end else begin
      m_click = lh[2] && !lh[3];
      m_tick = f_tick();
      m_stp = f_step();
      m_spd = f_speed();
      dp_step = m_stp;
      dp_dir = (m_phase == P_FALL);
      dp_speed = m_spd;
      if (m_stp) begin
        m_dir = dp_dir;
        m_n++;
      end
      case (m_phase)
        P_IDLE, P_SETTLED: if (m_click) begin m_phase = P_CAP; m_bounce = 0; end
        P_CAP: begin
          m_h = (int'(bus.ypos) < FLOOR) ? FLOOR - int'(bus.ypos) : 0;
          m_n = 0;
          m_phase = (m_h < MIN_H) ? P_SETTLED : P_FALL;
        end
        P_FALL: if (m_tick && int'(bus.ypos) >= FLOOR) begin
          if (m_bounce < 15) m_bounce++;
          m_h = m_h / 2;
          m_s0 = m_spd;
          m_n = 0;
          if (m_h < MIN_H) m_phase = P_SETTLED;
          else begin
            m_phase = P_RISE;
            m_target = FLOOR - m_h;
            m_targets.push_back(m_target);
          end
        end
        P_RISE: if (m_tick && int'(bus.ypos) <= m_target) begin
          m_phase = P_FALL;
          m_n = 0;
        end
        default: m_phase = P_IDLE;
      endcase
      lh[3] = lh[2]; lh[2] = lh[1]; lh[1] = lh[0]; lh[0] = bus.left;
      m_vb_prev = bus.vblnk;
    end
  end

  // bench-side motion datapath: moves ypos after each modelled step, clamps at the floor
  initial forever begin
    int ny;
    @(posedge clk);
    #1;
    if (dp_auto && dp_step) begin
      if (dp_dir) begin
        ny = int'(bus.ypos) + dp_speed;
        if (ny > FLOOR) ny = FLOOR;
      end else begin
        ny = int'(bus.ypos) - dp_speed;
      end
      bus.ypos = 12'(ny);
    end
  end

  // ---------------- scoreboard / per-cycle compare ----------------
  logic [SW-1:0] exp_q [$];
  logic [SW-1:0] act_q [$];
  bit log_en = 0;
  int max_spd = 0;
  int dut_steps = 0;
  int dut_caps = 0;

  always @(negedge clk) begin
    check("capture", bus.capture, (m_phase == P_CAP));
    check("step", bus.step, f_step());
    check("dir_down", bus.dir_down, f_dir());
    check("speed", bus.speed, f_speed());
    check("settled", bus.settled, (m_phase == P_SETTLED));
    check("bounce_cnt", bus.bounce_cnt, m_bounce);
    if (bus.step === 1'b1) begin
      dut_steps++;
      if (log_en) begin
        if (act_q.size() < 9) act_q.push_back(bus.speed);
        if (int'(bus.speed) > max_spd) max_spd = int'(bus.speed);
      end
    end
    if (bus.capture === 1'b1) dut_caps++;
  end

  // ---------------- driver tasks (all start and end at a posedge) ----------------
  task automatic frame(input int hi, input int lo, input logic lft);
    #2;
    bus.vblnk = 1'b1;
    bus.left = lft;
    repeat (hi) @(posedge clk);
    #2;
    bus.vblnk = 1'b0;
    repeat (lo) @(posedge clk);
  endtask

  task automatic click();
    #2;
    bus.left = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    bus.left = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  task automatic set_y(input int v);
    #1;
    bus.ypos = 12'(v);
    @(posedge clk);
  endtask

  task automatic wait_settled(input int max_frames);
    int f;
    bit done;
    f = 0;
    done = 0;
    while (!done && f < max_frames) begin
      frame(2, 3, 1'b0);
      #1;
      done = (bus.settled === 1'b1);
      @(posedge clk);
      f++;
    end
    check("settle_reached", done, 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_capture"}, bus.capture, 0);
    check({tag, "_step"}, bus.step, 0);
    check({tag, "_dir"}, bus.dir_down, 0);
    check({tag, "_speed"}, bus.speed, 0);
    check({tag, "_settled"}, bus.settled, 0);
    check({tag, "_bounce"}, bus.bounce_cnt, 0);
    check({tag, "_state"}, bus.state_dbg, 0);
  endtask

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion at %0t", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    int hit, s0, c0;
    bus.vblnk = 1'b0;
    bus.left = 1'b0;
    bus.ypos = 12'd0;
    #1 rst_n = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    #3;
    check_outputs_zero("reset");
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // capture latency from a click at ypos=136
    set_y(136);
    #2 bus.left = 1'b1;
    hit = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #3;
      if (bus.capture === 1'b1 && hit == 0) hit = k;
    end
    bus.left = 1'b0;
    @(posedge clk);
    check("capture_latency", hit, 4);
    repeat (4) @(posedge clk);

    // full bounce sequence with the datapath moving ypos
    exp_q = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd2, 4'd3};
    log_en = 1;
    dp_auto = 1;
    wait_settled(700);
    log_en = 0;
    check("speed_log_len", act_q.size(), 9);
    for (int i = 0; i < 9; i++)
      if (i < act_q.size()) check("speed_seq", act_q[i], exp_q[i]);
    check("max_speed", max_spd, 8);
    check("target_count", m_targets.size(), 4);
    if (m_targets.size() == 4) begin
      check("target0", m_targets[0], 336);
      check("target1", m_targets[1], 436);
      check("target2", m_targets[2], 486);
      check("target3", m_targets[3], 511);
    end
    check("model_h_final", m_h, 12);
    #1;
    check("bounce_final", bus.bounce_cnt, 5);
    check("settled_final", bus.settled, 1);
    @(posedge clk);

    // click at ypos=530 from SETTLED: new capture, no motion, counter cleared
    dp_auto = 0;
    set_y(530);
    c0 = dut_caps;
    s0 = dut_steps;
    click();
    repeat (5) frame(2, 3, 1'b0);
    check("low_drop_caps", dut_caps - c0, 1);
    check("low_drop_steps", dut_steps - s0, 0);
    #1;
    check("low_drop_bounce", bus.bounce_cnt, 0);
    check("low_drop_settled", bus.settled, 1);
    @(posedge clk);

    // clicks while falling are ignored
    set_y(136);
    dp_auto = 1;
    click();
    c0 = dut_caps;
    for (int i = 0; i < 40; i++) frame(2, 4, logic'(i % 2));
    bus.left = 1'b0;
    check("fall_click_caps", dut_caps - c0, 0);

    // reset asserted inside a stepping tick
    #2 bus.vblnk = 1'b1;
    #1;
    check("pre_reset_step", bus.step, 1);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    @(posedge clk);
    #2 bus.vblnk = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    dp_auto = 0;
    s0 = dut_steps;
    repeat (10) frame(2, 3, 1'b0);
    check("post_reset_steps", dut_steps - s0, 0);

    // exact-target reversal and long vblnk, ypos driven by hand
    set_y(136);
    click();
    s0 = dut_steps;
    repeat (5) frame(2, 3, 1'b0);
    check("manual_fall_steps", dut_steps - s0, 5);
    set_y(536);
    frame(2, 3, 1'b0);
    #1;
    check("manual_impact_bounce", bus.bounce_cnt, 1);
    check("manual_kept_speed", bus.speed, 2);
    @(posedge clk);
    c0 = dut_caps;
    click();
    check("rise_click_caps", dut_caps - c0, 0);
    set_y(400);
    s0 = dut_steps;
    frame(2, 3, 1'b0);
    check("rise_step", dut_steps - s0, 1);
    #1;
    check("rise_dir_hold", bus.dir_down, 0);
    @(posedge clk);
    set_y(336);
    s0 = dut_steps;
    frame(2, 3, 1'b0);
    check("target_tick_steps", dut_steps - s0, 0);
    #1;
    check("target_tick_speed", bus.speed, 1);
    @(posedge clk);
    s0 = dut_steps;
    frame(50, 5, 1'b0);
    check("long_vblnk_steps", dut_steps - s0, 1);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
